// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters.
// Presents the owner's word as a 1-deep TX FIFO and returns the RX word to the owner.
module spi_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_lock,
  input  logic [16*NREQ-1:0] i_req_data,
  input  logic [2*NREQ-1:0]  i_req_ss,
  input  logic [NREQ-1:0]    i_req_wls,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic               o_err,
  output logic [15:0]        o_rx_data,
  output logic [15:0]        o_spi_tx_data,
  output logic               o_spi_tx_empty,
  output logic               o_spi_tx_full,
  input  logic               i_spi_tx_rd,
  input  logic [15:0]        i_spi_rx_data,
  input  logic               i_spi_rx_wr,
  output logic               o_spi_rx_empty,
  output logic               o_spi_rx_full,
  output logic [1:0]         o_spi_ss,
  output logic               o_spi_wls
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]      r_state,    w_state_nxt;
  logic [PW-1:0]   r_ptr,      w_ptr_nxt;
  logic [PW-1:0]   r_owner,    w_owner_nxt;
  logic            r_lock,     w_lock_nxt;
  logic [CW-1:0]   r_wd_cnt,   w_wd_cnt_nxt;
  logic [NREQ-1:0] r_gnt,      w_gnt_nxt;
  logic [NREQ-1:0] r_done,     w_done_nxt;
  logic            r_err,      w_err_nxt;
  logic [DW-1:0]   r_rx_data,  w_rx_data_nxt;
  logic [DW-1:0]   r_tx_data,  w_tx_data_nxt;
  logic            r_tx_empty, w_tx_empty_nxt;
  logic            r_tx_full,  w_tx_full_nxt;
  logic [SW-1:0]   r_ss,       w_ss_nxt;
  logic            r_wls,      w_wls_nxt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic            w_timeout;

  // Winner: a locked previous owner keeps the master, else first request at or after r_ptr
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    if (r_lock && i_req[r_owner]) begin
      w_found = 1'b1;
      w_win   = r_owner;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        v_idx = (32'(r_ptr) + 32'(i)) % NREQ;
        if (!w_found && i_req[v_idx]) begin
          w_found = 1'b1;
          w_win   = PW'(v_idx);
        end
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wd_cnt == CW'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_lock_nxt     = r_lock;
    w_wd_cnt_nxt   = r_wd_cnt;
    w_gnt_nxt      = '0;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    w_tx_data_nxt  = r_tx_data;
    w_tx_empty_nxt = r_tx_empty;
    w_tx_full_nxt  = r_tx_full;
    w_ss_nxt       = r_ss;
    w_wls_nxt      = r_wls;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt      = S_LOAD;
          w_owner_nxt      = w_win;
          w_ptr_nxt        = PW'((32'(w_win) + 32'd1) % NREQ);
          w_lock_nxt       = i_req_lock[w_win];
          w_tx_data_nxt    = i_req_data[DW*32'(w_win) +: DW];
          w_ss_nxt         = i_req_ss[SW*32'(w_win) +: SW];
          w_wls_nxt        = i_req_wls[w_win];
          w_gnt_nxt[w_win] = 1'b1;
          w_tx_empty_nxt   = 1'b0;
          w_tx_full_nxt    = 1'b1;
        end
      end
      S_LOAD: begin
        if (i_spi_tx_rd) begin
          w_state_nxt    = S_XFER;
          w_tx_empty_nxt = 1'b1;
          w_tx_full_nxt  = 1'b0;
          w_wd_cnt_nxt   = '0;
        end
      end
      S_XFER: begin
        // A received word on the timeout edge still counts as a good transfer
        if (i_spi_rx_wr) begin
          w_state_nxt          = S_IDLE;
          w_rx_data_nxt        = r_wls ? i_spi_rx_data : {8'h00, i_spi_rx_data[7:0]};
          w_done_nxt[r_owner]  = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt          = S_IDLE;
          w_rx_data_nxt        = '0;
          w_err_nxt            = 1'b1;
          w_done_nxt[r_owner]  = 1'b1;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock     <= 1'b0;
      r_wd_cnt   <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_rx_data  <= '0;
      r_tx_data  <= '0;
      r_tx_empty <= 1'b1;
      r_tx_full  <= 1'b0;
      r_ss       <= '0;
      r_wls      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock     <= w_lock_nxt;
      r_wd_cnt   <= w_wd_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_empty <= w_tx_empty_nxt;
      r_tx_full  <= w_tx_full_nxt;
      r_ss       <= w_ss_nxt;
      r_wls      <= w_wls_nxt;
    end
  end

  assign o_gnt          = r_gnt;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_rx_data      = r_rx_data;
  assign o_spi_tx_data  = r_tx_data;
  assign o_spi_tx_empty = r_tx_empty;
  assign o_spi_tx_full  = r_tx_full;
  assign o_spi_ss       = r_ss;
  assign o_spi_wls      = r_wls;
  assign o_spi_rx_empty = 1'b1;
  assign o_spi_rx_full  = 1'b0;

endmodule
